// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vga_timing_pkg
// Description : 640x480@60 timing constants, coordinate types and helpers
//               shared by the sync generator and the pixel generators.
// Revision    : 1.0 - initial release
// ============================================================================
package vga_timing_pkg;

    localparam int COORD_W   = 10;
    localparam int DIV_CNT_W = 4;

    localparam int HD = 640;
    localparam int HF = 16;
    localparam int HS = 96;
    localparam int HB = 48;
    localparam int VD = 480;
    localparam int VF = 10;
    localparam int VS = 2;
    localparam int VB = 33;

    localparam int H_TOTAL      = HD + HF + HS + HB;
    localparam int V_TOTAL      = VD + VF + VS + VB;
    localparam int H_SYNC_START = HD + HF;
    localparam int H_SYNC_END   = HD + HF + HS - 1;
    localparam int V_SYNC_START = VD + VF;
    localparam int V_SYNC_END   = VD + VF + VS - 1;

    typedef logic [COORD_W-1:0]   coord_t;
    typedef logic [DIV_CNT_W-1:0] div_cnt_t;

    function automatic logic in_range(input coord_t v, input coord_t lo, input coord_t hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_if
// Description : Registered timing bundle from the sync generator to the
//               pixel generators and the connector.
// Revision    : 1.0 - initial release
// ============================================================================
interface vga_sync_if;
    import vga_timing_pkg::*;

    logic   p_tick;
    coord_t pixel_x;
    coord_t pixel_y;
    logic   video_on;
    logic   hsync_n;
    logic   vsync_n;
    logic   frame_start;

    modport master (
        output p_tick, pixel_x, pixel_y, video_on, hsync_n, vsync_n, frame_start
    );

    modport slave (
        input  p_tick, pixel_x, pixel_y, video_on, hsync_n, vsync_n, frame_start
    );
endinterface
`default_nettype wire

// File: rtl/vga_sync_gen_pixel_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : pixel_tick_gen
// Description : Divides the system clock by CLK_DIV; o_advance is high on the
//               clock edge where the pixel counters must step.
// Revision    : 1.0 - initial release
// ============================================================================
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  wire  clk,
    input  wire  reset_n,
    output logic o_advance
);
    import vga_timing_pkg::*;

    localparam div_cnt_t c_DIV_LAST = div_cnt_t'(CLK_DIV - 1);

    div_cnt_t r_div_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_div_cnt <= '0;
        end else if (r_div_cnt == c_DIV_LAST) begin
            r_div_cnt <= '0;
        end else begin
            r_div_cnt <= r_div_cnt + div_cnt_t'(1);
        end
    end

    // With CLK_DIV=1 the counter sits at 0 and every edge advances.
    assign o_advance = (r_div_cnt == c_DIV_LAST);

endmodule
`default_nettype wire

// File: rtl/vga_sync_gen.sv
`default_nettype none
// ============================================================================
// Module      : vga_sync_gen
// Description : VGA timing source: pixel/line counters plus registered
//               video_on, sync and frame_start flags aligned to coordinates.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_sync_gen #(
    parameter int CLK_DIV = 4,
    parameter int HD      = vga_timing_pkg::HD,
    parameter int HF      = vga_timing_pkg::HF,
    parameter int HS      = vga_timing_pkg::HS,
    parameter int HB      = vga_timing_pkg::HB,
    parameter int VD      = vga_timing_pkg::VD,
    parameter int VF      = vga_timing_pkg::VF,
    parameter int VS      = vga_timing_pkg::VS,
    parameter int VB      = vga_timing_pkg::VB
) (
    input  wire         clk,
    input  wire         reset_n,
    vga_sync_if.master  vga
);
    import vga_timing_pkg::*;

    localparam coord_t c_H_LAST     = coord_t'(HD + HF + HS + HB - 1);
    localparam coord_t c_V_LAST     = coord_t'(VD + VF + VS + VB - 1);
    localparam coord_t c_HD         = coord_t'(HD);
    localparam coord_t c_VD         = coord_t'(VD);
    localparam coord_t c_HSYNC_LO   = coord_t'(HD + HF);
    localparam coord_t c_HSYNC_HI   = coord_t'(HD + HF + HS - 1);
    localparam coord_t c_VSYNC_LO   = coord_t'(VD + VF);
    localparam coord_t c_VSYNC_HI   = coord_t'(VD + VF + VS - 1);

    logic   w_advance;
    coord_t w_x_next;
    coord_t w_y_next;

    logic   r_p_tick;
    coord_t r_x;
    coord_t r_y;
    logic   r_video_on;
    logic   r_hsync_n;
    logic   r_vsync_n;
    logic   r_frame_start;

    pixel_tick_gen #(
        .CLK_DIV   (CLK_DIV)
    ) u_pixel_tick_gen (
        .clk       (clk),
        .reset_n   (reset_n),
        .o_advance (w_advance)
    );

    always_comb begin
        w_x_next = r_x + coord_t'(1);
        w_y_next = r_y;
        if (r_x == c_H_LAST) begin
            w_x_next = '0;
            w_y_next = (r_y == c_V_LAST) ? '0 : r_y + coord_t'(1);
        end
    end

    // Flags are derived from the next coordinates so they land in the same
    // clock as the coordinates they describe.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_p_tick      <= 1'b0;
            r_x           <= '0;
            r_y           <= '0;
            r_video_on    <= 1'b0;
            r_hsync_n     <= 1'b1;
            r_vsync_n     <= 1'b1;
            r_frame_start <= 1'b0;
        end else begin
            r_p_tick      <= w_advance;
            r_frame_start <= 1'b0;
            if (w_advance) begin
                r_x           <= w_x_next;
                r_y           <= w_y_next;
                r_video_on    <= (w_x_next < c_HD) && (w_y_next < c_VD);
                r_hsync_n     <= !in_range(w_x_next, c_HSYNC_LO, c_HSYNC_HI);
                r_vsync_n     <= !in_range(w_y_next, c_VSYNC_LO, c_VSYNC_HI);
                r_frame_start <= (w_x_next == '0) && (w_y_next == '0);
            end
        end
    end

    assign vga.p_tick      = r_p_tick;
    assign vga.pixel_x     = r_x;
    assign vga.pixel_y     = r_y;
    assign vga.video_on    = r_video_on;
    assign vga.hsync_n     = r_hsync_n;
    assign vga.vsync_n     = r_vsync_n;
    assign vga.frame_start = r_frame_start;

endmodule
`default_nettype wire
